// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin front end for a 1024x32 single-port data
//               memory with byte lanes, load extension and a response hold stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int NREQ   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        in_req_valid,
    output logic [NREQ-1:0]        out_req_ready,
    input  logic [NREQ*ADDR_W-1:0] in_req_addr,
    input  logic [NREQ-1:0]        in_req_we,
    input  logic [2*NREQ-1:0]      in_req_size,
    input  logic [NREQ-1:0]        in_req_unsigned,
    input  logic [32*NREQ-1:0]     in_req_wdata,
    output logic [NREQ-1:0]        out_rsp_valid,
    input  logic [NREQ-1:0]        in_rsp_ready,
    output logic [31:0]            out_rsp_data,
    output logic                   out_rsp_err,
    output logic [ADDR_W-3:0]      out_mem_addr,
    output logic                   out_mem_rw_mode,
    output logic [31:0]            out_mem_write_data,
    output logic [3:0]             out_mem_byte_en,
    input  logic [31:0]            in_mem_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RESP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        own_q, own_d;
    logic        last_grant_q, last_grant_d;
    logic        err_q, err_d;
    logic        load_q, load_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] hold_q, hold_d;

    logic              w_rsp_active;
    logic              w_rsp_accept;
    logic              w_can_issue;
    logic [NREQ-1:0]   w_grant;
    logic              w_issue;
    logic              w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic              w_sel_uns;
    logic [31:0]       w_sel_wdata;
    logic              w_legal;
    logic [3:0]        w_lane_mask;
    logic [31:0]       w_lane_data;
    logic [31:0]       w_live_data;

    // Shift the addressed lane down, then trim to size and extend.
    function automatic logic [31:0] f_format(input logic [31:0] raw,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration and request decode
    // ------------------------------------------------------------------
    assign w_rsp_active = (state_q != S_IDLE);
    assign w_rsp_accept = w_rsp_active & in_rsp_ready[own_q];
    assign w_can_issue  = i_rst_n & (~w_rsp_active | w_rsp_accept);

    always_comb begin
        w_grant = '0;
        if (w_can_issue) begin
            if (in_req_valid == 2'b11) begin
                w_grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                w_grant = in_req_valid;
            end
        end
    end

    assign w_issue       = |w_grant;
    assign w_sel         = w_grant[1];
    assign out_req_ready = w_grant;

    assign w_sel_addr  = w_sel ? in_req_addr[2*ADDR_W-1:ADDR_W] : in_req_addr[ADDR_W-1:0];
    assign w_sel_we    = w_sel ? in_req_we[1]         : in_req_we[0];
    assign w_sel_size  = w_sel ? in_req_size[3:2]     : in_req_size[1:0];
    assign w_sel_uns   = w_sel ? in_req_unsigned[1]   : in_req_unsigned[0];
    assign w_sel_wdata = w_sel ? in_req_wdata[63:32]  : in_req_wdata[31:0];

    always_comb begin
        w_legal     = 1'b0;
        w_lane_mask = 4'b0000;
        w_lane_data = w_sel_wdata;
        case (w_sel_size)
            SZ_BYTE: begin
                w_legal     = 1'b1;
                w_lane_mask = 4'b0001 << w_sel_addr[1:0];
                w_lane_data = {4{w_sel_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_legal     = ~w_sel_addr[0];
                w_lane_mask = 4'b0011 << w_sel_addr[1:0];
                w_lane_data = {2{w_sel_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_legal     = (w_sel_addr[1:0] == 2'b00);
                w_lane_mask = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_live_data = load_q ? f_format(in_mem_data, off_q, size_q, uns_q) : 32'h0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            own_q        <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            hold_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            load_q       <= load_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            hold_q       <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        load_d       = load_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        hold_d       = hold_q;

        if (w_issue) begin
            state_d      = S_RESP;
            own_d        = w_sel;
            last_grant_d = w_sel;
            err_d        = ~w_legal;
            load_d       = w_legal & ~w_sel_we;
            uns_d        = w_sel_uns;
            size_d       = w_sel_size;
            off_d        = w_sel_addr[1:0];
        end else if (!w_rsp_active || w_rsp_accept) begin
            state_d = S_IDLE;
        end else begin
            state_d = S_HOLD;
        end

        // Memory read data is only valid for one cycle; freeze it on a stall.
        if (state_q == S_RESP && !w_rsp_accept) begin
            hold_d = w_live_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_mem_addr       = '0;
        out_mem_rw_mode    = 1'b0;
        out_mem_write_data = 32'h0;
        out_mem_byte_en    = 4'b0000;
        if (w_issue && w_legal) begin
            out_mem_addr    = w_sel_addr[ADDR_W-1:2];
            out_mem_rw_mode = w_sel_we;
            out_mem_byte_en = w_lane_mask;
            if (w_sel_we) begin
                out_mem_write_data = w_lane_data;
            end
        end

        out_rsp_valid = 2'b00;
        out_rsp_data  = 32'h0;
        out_rsp_err   = 1'b0;
        case (state_q)
            S_RESP: begin
                out_rsp_valid = own_q ? 2'b10 : 2'b01;
                out_rsp_data  = w_live_data;
                out_rsp_err   = err_q;
            end
            S_HOLD: begin
                out_rsp_valid = own_q ? 2'b10 : 2'b01;
                out_rsp_data  = hold_q;
                out_rsp_err   = err_q;
            end
            default: begin
                out_rsp_valid = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a behavioural 1024x32 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct packed {
        logic        v;
        logic [11:0] a;
        logic        we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] wd;
    } req_t;

    typedef struct packed {
        req_t        r0;
        req_t        r1;
        logic [1:0]  rdy;
        logic [1:0]  gnt;
        logic [31:0] d;
        logic        e;
        logic        mchk;
        logic        m_rw;
        logic [9:0]  m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wd;
    } row_t;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam req_t NOREQ = '0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_req_valid;
    logic [1:0]  out_req_ready;
    logic [23:0] in_req_addr;
    logic [1:0]  in_req_we;
    logic [3:0]  in_req_size;
    logic [1:0]  in_req_unsigned;
    logic [63:0] in_req_wdata;
    logic [1:0]  out_rsp_valid;
    logic [1:0]  in_rsp_ready;
    logic [31:0] out_rsp_data;
    logic        out_rsp_err;
    logic [9:0]  out_mem_addr;
    logic        out_mem_rw_mode;
    logic [31:0] out_mem_write_data;
    logic [3:0]  out_mem_byte_en;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    exp_t e;
    row_t tbl[$];

    mem_arbiter #(.ADDR_W(12), .NREQ(2)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .in_req_valid       (in_req_valid),
        .out_req_ready      (out_req_ready),
        .in_req_addr        (in_req_addr),
        .in_req_we          (in_req_we),
        .in_req_size        (in_req_size),
        .in_req_unsigned    (in_req_unsigned),
        .in_req_wdata       (in_req_wdata),
        .out_rsp_valid      (out_rsp_valid),
        .in_rsp_ready       (in_rsp_ready),
        .out_rsp_data       (out_rsp_data),
        .out_rsp_err        (out_rsp_err),
        .out_mem_addr       (out_mem_addr),
        .out_mem_rw_mode    (out_mem_rw_mode),
        .out_mem_write_data (out_mem_write_data),
        .out_mem_byte_en    (out_mem_byte_en),
        .in_mem_data        (mem_rdata)
    );

    always #5 clk = ~clk;

    // Sync-write, registered-read RAM with byte enables.
    always @(posedge clk) begin
        if (out_mem_rw_mode) begin
            for (int b = 0; b < 4; b++) begin
                if (out_mem_byte_en[b]) mem[out_mem_addr][8*b +: 8] <= out_mem_write_data[8*b +: 8];
            end
        end
        mem_rdata <= mem[out_mem_addr];
    end

    function automatic req_t ld(input logic [11:0] a, input logic [1:0] sz, input logic u);
        req_t r;
        r = '0; r.v = 1'b1; r.a = a; r.sz = sz; r.u = u;
        return r;
    endfunction

    function automatic req_t st(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd);
        req_t r;
        r = '0; r.v = 1'b1; r.a = a; r.sz = sz; r.we = 1'b1; r.wd = wd;
        return r;
    endfunction

    task automatic drive(input req_t r0, input req_t r1, input logic [1:0] rdy);
        in_req_valid    = {r1.v, r0.v};
        in_req_addr     = {r1.a, r0.a};
        in_req_we       = {r1.we, r0.we};
        in_req_size     = {r1.sz, r0.sz};
        in_req_unsigned = {r1.u, r0.u};
        in_req_wdata    = {r1.wd, r0.wd};
        in_rsp_ready    = rdy;
    endtask

    task automatic test_reset();
        logic [31:0] snap;
        rst_n = 1'b0;
        drive(st(12'h014, SZ_W, 32'hFFFF_FFFF), NOREQ, 2'b11);
        @(negedge clk);
        snap = mem[5];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (out_req_ready !== 2'b00 || out_mem_rw_mode !== 1'b0 ||
                out_rsp_valid !== 2'b00 || out_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got ready=%b rw=%b rsp_valid=%b err=%b, required 00 0 00 0",
                         out_req_ready, out_mem_rw_mode, out_rsp_valid, out_rsp_err);
            end
        end
        checks++;
        if (mem[5] !== snap) begin
            errors++;
            $display("FAIL reset_mem: got mem[5]=%h, required %h", mem[5], snap);
        end
        @(negedge clk);
        drive(NOREQ, NOREQ, 2'b11);
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        tbl.delete();
        tbl.push_back('{st(12'h000, SZ_W, 32'h55AA_55AA), NOREQ, 2'b11, 2'b01, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd0, 4'b1111, 32'h55AA_55AA});
        tbl.push_back('{st(12'h020, SZ_W, 32'h1234_5678), NOREQ, 2'b11, 2'b01, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd8, 4'b1111, 32'h1234_5678});
        tbl.push_back('{st(12'h024, SZ_W, 32'h0BAD_F00D), NOREQ, 2'b11, 2'b01, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd9, 4'b1111, 32'h0BAD_F00D});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL preload_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL preload_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL preload_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be ||
                    (tbl[i].m_be != 4'b0 && out_mem_addr !== tbl[i].m_addr) ||
                    (tbl[i].m_rw && out_mem_write_data !== tbl[i].m_wd)) begin
                    errors++;
                    $display("FAIL preload_mem row %0d: got rw=%b a=%0d be=%b wd=%h, required rw=%b a=%0d be=%b wd=%h",
                             i, out_mem_rw_mode, out_mem_addr, out_mem_byte_en, out_mem_write_data,
                             tbl[i].m_rw, tbl[i].m_addr, tbl[i].m_be, tbl[i].m_wd);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL preload_drain: got %0d pending, required 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_store_load_word();
        tbl.delete();
        tbl.push_back('{NOREQ, st(12'h010, SZ_W, 32'hDEAD_BEEF), 2'b11, 2'b10, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd4, 4'b1111, 32'hDEAD_BEEF});
        tbl.push_back('{NOREQ, ld(12'h010, SZ_W, 1'b0), 2'b11, 2'b10, 32'hDEAD_BEEF, 1'b0,
                        1'b1, 1'b0, 10'd4, 4'b1111, 32'h0});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL word_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL word_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL word_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be ||
                    (tbl[i].m_be != 4'b0 && out_mem_addr !== tbl[i].m_addr) ||
                    (tbl[i].m_rw && out_mem_write_data !== tbl[i].m_wd)) begin
                    errors++;
                    $display("FAIL word_mem row %0d: got rw=%b a=%0d be=%b wd=%h, required rw=%b a=%0d be=%b wd=%h",
                             i, out_mem_rw_mode, out_mem_addr, out_mem_byte_en, out_mem_write_data,
                             tbl[i].m_rw, tbl[i].m_addr, tbl[i].m_be, tbl[i].m_wd);
                end
            end
        end
        checks++;
        if (sbq.size() != 0 || out_rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL word_drain: got %0d pending valid=%b, required 0 00", sbq.size(), out_rsp_valid);
        end
        sbq.delete();
    endtask

    task automatic test_byte_extend();
        tbl.delete();
        tbl.push_back('{NOREQ, st(12'h013, SZ_B, 32'h0000_0080), 2'b11, 2'b10, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd4, 4'b1000, 32'h8080_8080});
        tbl.push_back('{NOREQ, ld(12'h013, SZ_B, 1'b0), 2'b11, 2'b10, 32'hFFFF_FF80, 1'b0,
                        1'b1, 1'b0, 10'd4, 4'b1000, 32'h0});
        tbl.push_back('{NOREQ, ld(12'h013, SZ_B, 1'b1), 2'b11, 2'b10, 32'h0000_0080, 1'b0,
                        1'b1, 1'b0, 10'd4, 4'b1000, 32'h0});
        tbl.push_back('{NOREQ, ld(12'h012, SZ_H, 1'b0), 2'b11, 2'b10, 32'hFFFF_80AD, 1'b0,
                        1'b1, 1'b0, 10'd4, 4'b1100, 32'h0});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL byte_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL byte_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL byte_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be ||
                    (tbl[i].m_be != 4'b0 && out_mem_addr !== tbl[i].m_addr) ||
                    (tbl[i].m_rw && out_mem_write_data !== tbl[i].m_wd)) begin
                    errors++;
                    $display("FAIL byte_mem row %0d: got rw=%b a=%0d be=%b wd=%h, required rw=%b a=%0d be=%b wd=%h",
                             i, out_mem_rw_mode, out_mem_addr, out_mem_byte_en, out_mem_write_data,
                             tbl[i].m_rw, tbl[i].m_addr, tbl[i].m_be, tbl[i].m_wd);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL byte_drain: got %0d pending, required 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_round_robin();
        tbl.delete();
        for (int i = 0; i < 6; i++) begin
            tbl.push_back('{ld(12'h020, SZ_W, 1'b0), ld(12'h024, SZ_W, 1'b0), 2'b11,
                            (i % 2 == 0) ? 2'b01 : 2'b10,
                            (i % 2 == 0) ? 32'h1234_5678 : 32'h0BAD_F00D, 1'b0,
                            1'b1, 1'b0, (i % 2 == 0) ? 10'd8 : 10'd9, 4'b1111, 32'h0});
        end
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if (i > 0) begin
                checks++;
                if (out_rsp_valid === 2'b00) begin
                    errors++;
                    $display("FAIL rr_throughput row %0d: got no response, required one per cycle", i);
                end
            end
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rr_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rr_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL rr_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be ||
                    out_mem_addr !== tbl[i].m_addr) begin
                    errors++;
                    $display("FAIL rr_mem row %0d: got rw=%b a=%0d be=%b, required rw=%b a=%0d be=%b",
                             i, out_mem_rw_mode, out_mem_addr, out_mem_byte_en,
                             tbl[i].m_rw, tbl[i].m_addr, tbl[i].m_be);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got %0d pending, required 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_illegal();
        tbl.delete();
        tbl.push_back('{NOREQ, ld(12'h003, SZ_H, 1'b0), 2'b11, 2'b10, 32'h0, 1'b1,
                        1'b1, 1'b0, 10'd0, 4'b0000, 32'h0});
        tbl.push_back('{NOREQ, st(12'h022, SZ_W, 32'hFFFF_FFFF), 2'b11, 2'b10, 32'h0, 1'b1,
                        1'b1, 1'b0, 10'd0, 4'b0000, 32'h0});
        tbl.push_back('{ld(12'h000, SZ_X, 1'b0), NOREQ, 2'b11, 2'b01, 32'h0, 1'b1,
                        1'b1, 1'b0, 10'd0, 4'b0000, 32'h0});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL illegal_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL illegal_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL illegal_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be) begin
                    errors++;
                    $display("FAIL illegal_mem row %0d: got rw=%b be=%b, required rw=%b be=%b",
                             i, out_mem_rw_mode, out_mem_byte_en, tbl[i].m_rw, tbl[i].m_be);
                end
            end
        end
        checks++;
        if (sbq.size() != 0 || mem[0] !== 32'h55AA_55AA || mem[8] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL illegal_memstate: got pend=%0d mem0=%h mem8=%h, required 0 55aa55aa 12345678",
                     sbq.size(), mem[0], mem[8]);
        end
        sbq.delete();
    endtask

    task automatic test_backpressure();
        tbl.delete();
        tbl.push_back('{NOREQ, ld(12'h020, SZ_W, 1'b0), 2'b11, 2'b10, 32'h1234_5678, 1'b0,
                        1'b1, 1'b0, 10'd8, 4'b1111, 32'h0});
        for (int i = 0; i < 3; i++) begin
            tbl.push_back('{st(12'h020, SZ_W, 32'h0), NOREQ, 2'b00, 2'b00, 32'h0, 1'b0,
                            1'b1, 1'b0, 10'd0, 4'b0000, 32'h0});
        end
        tbl.push_back('{st(12'h020, SZ_W, 32'h0), NOREQ, 2'b11, 2'b01, 32'h0, 1'b0,
                        1'b1, 1'b1, 10'd8, 4'b1111, 32'h0});
        tbl.push_back('{NOREQ, NOREQ, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 4'b0000, 32'h0});
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy);
            #1;
            if (tbl[i].rdy == 2'b00) begin
                checks++;
                if (out_rsp_valid !== 2'b10 || out_rsp_data !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL bp_hold row %0d: got v=%b d=%h, required v=10 d=12345678",
                             i, out_rsp_valid, out_rsp_data);
                end
            end
            if ((out_rsp_valid & in_rsp_ready) != 2'b00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL bp_rsp: got valid=%b, required none", out_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL bp_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                                 out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
                    end
                end
            end
            checks++;
            if (out_req_ready !== tbl[i].gnt) begin
                errors++;
                $display("FAIL bp_grant row %0d: got %b, required %b", i, out_req_ready, tbl[i].gnt);
            end
            if (tbl[i].gnt != 2'b00) sbq.push_back('{tbl[i].gnt, tbl[i].d, tbl[i].e});
            if (tbl[i].mchk) begin
                checks++;
                if (out_mem_rw_mode !== tbl[i].m_rw || out_mem_byte_en !== tbl[i].m_be ||
                    (tbl[i].m_be != 4'b0 && out_mem_addr !== tbl[i].m_addr)) begin
                    errors++;
                    $display("FAIL bp_mem row %0d: got rw=%b a=%0d be=%b, required rw=%b a=%0d be=%b",
                             i, out_mem_rw_mode, out_mem_addr, out_mem_byte_en,
                             tbl[i].m_rw, tbl[i].m_addr, tbl[i].m_be);
                end
            end
        end
        checks++;
        if (sbq.size() != 0 || mem[8] !== 32'h0) begin
            errors++;
            $display("FAIL bp_drain: got pend=%0d mem8=%h, required 0 00000000", sbq.size(), mem[8]);
        end
        sbq.delete();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        drive(NOREQ, ld(12'h024, SZ_W, 1'b0), 2'b11);
        #1;
        checks++;
        if (out_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL midrst_issue: got %b, required 10", out_req_ready);
        end
        @(negedge clk);
        drive(st(12'h024, SZ_W, 32'hFFFF_FFFF), NOREQ, 2'b00);
        #1;
        checks++;
        if (out_rsp_valid !== 2'b10) begin
            errors++;
            $display("FAIL midrst_pending: got valid=%b, required 10", out_rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_rsp_valid !== 2'b00 || out_req_ready !== 2'b00 || out_mem_rw_mode !== 1'b0) begin
                errors++;
                $display("FAIL midrst_forced cycle %0d: got v=%b ready=%b rw=%b, required 00 00 0",
                         i, out_rsp_valid, out_req_ready, out_mem_rw_mode);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (mem[9] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL midrst_mem: got mem9=%h, required 0badf00d", mem[9]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(ld(12'h024, SZ_W, 1'b0), ld(12'h020, SZ_W, 1'b0), 2'b11);
        #1;
        checks++;
        if (out_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_tie: got %b, required 01", out_req_ready);
        end
        sbq.push_back('{2'b01, 32'h0BAD_F00D, 1'b0});
        @(negedge clk);
        drive(NOREQ, NOREQ, 2'b11);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL midrst_rsp: got empty scoreboard, required one entry");
        end else begin
            e = sbq.pop_front();
            if (out_rsp_valid !== e.vld || out_rsp_data !== e.data || out_rsp_err !== e.err) begin
                errors++;
                $display("FAIL midrst_rsp: got v=%b d=%h e=%b, required v=%b d=%h e=%b",
                         out_rsp_valid, out_rsp_data, out_rsp_err, e.vld, e.data, e.err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(NOREQ, NOREQ, 2'b00);
        test_reset();
        test_preload();
        test_store_load_word();
        test_byte_extend();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
